// File: rtl/smp_pkg.sv
// Shared types and default widths for the SMP main-memory controller.
package smp_pkg;

   localparam int SMP_ADDR_W = 11;
   localparam int SMP_DATA_W = 16;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      RD_WAIT,
      RSP,
      WR_WAIT
   } mem_ctrl_state_t;

endpackage

// File: rtl/smp_mem_ctrl_if.sv
// Bus-side and memory-side signals of the memory controller.
// The slave modport is the controller's view; master is the environment's view.
interface smp_mem_ctrl_if #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 16
) ();

   logic              req_vld;
   logic [ADDR_W-1:0] req_addr;
   logic              req_rdy;
   logic              rsp_vld;
   logic [ADDR_W-1:0] rsp_addr;
   logic [DATA_W-1:0] rsp_data;
   logic              wb_vld;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic              wb_rdy;
   logic              mem_re;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  req_vld, req_addr, wb_vld, wb_addr, wb_data, mem_rdata,
      output req_rdy, rsp_vld, rsp_addr, rsp_data, wb_rdy,
             mem_re, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output req_vld, req_addr, wb_vld, wb_addr, wb_data, mem_rdata,
      input  req_rdy, rsp_vld, rsp_addr, rsp_data, wb_rdy,
             mem_re, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/smp_wb_fifo.sv
// Posted write-back buffer: circular FIFO with a combinational address
// compare over all occupied entries that reports the youngest matching data.
module smp_wb_fifo #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push_i,
   input  logic [ADDR_W-1:0] push_addr_i,
   input  logic [DATA_W-1:0] push_data_i,
   input  logic              pop_i,
   output logic [ADDR_W-1:0] head_addr_o,
   output logic [DATA_W-1:0] head_data_o,
   output logic              full_o,
   output logic              empty_o,
   input  logic [ADDR_W-1:0] cmp_addr_i,
   output logic              hit_o,
   output logic [DATA_W-1:0] hit_data_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q;
   logic [PTR_W-1:0]  rd_ptr_q;
   logic [PTR_W:0]    count_q;
   logic [PTR_W-1:0]  age [DEPTH];
   logic [DEPTH-1:0]  match;

   // An entry is live when its distance from the head is below the occupancy.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
         assign age[gi]   = PTR_W'(gi) - rd_ptr_q;
         assign match[gi] = ({1'b0, age[gi]} < count_q) && (addr_q[gi] == cmp_addr_i);
      end
   endgenerate

   // Walk from oldest to youngest so the last match seen is the youngest write.
   always_comb begin
      logic [PTR_W-1:0] idx;
      idx        = '0;
      hit_o      = 1'b0;
      hit_data_o = '0;
      for (int a = 0; a < DEPTH; a++) begin
         idx = rd_ptr_q + PTR_W'(a);
         if (match[idx]) begin
            hit_o      = 1'b1;
            hit_data_o = data_q[idx];
         end
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + (PTR_W+1)'(1);
            2'b01:   count_q <= count_q - (PTR_W+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Entry storage; contents need no reset because occupancy qualifies them.
   always_ff @(posedge clk) begin
      if (push_i) begin
         addr_q[wr_ptr_q] <= push_addr_i;
         data_q[wr_ptr_q] <= push_data_i;
      end
   end

   assign head_addr_o = addr_q[rd_ptr_q];
   assign head_data_o = data_q[rd_ptr_q];
   assign full_o      = (count_q == (PTR_W+1)'(DEPTH));
   assign empty_o     = (count_q == '0);

endmodule

// File: rtl/smp_mem_ctrl.sv
// Shared main-memory controller: block fills from the snooping bus and posted
// dirty write-backs drained to a fixed-latency single-port memory.
// Build option SMP_WB_FWD_EN: answer fills that hit the write-back buffer
// directly from the youngest matching entry. Without it, a matching fill is
// held off while the buffer drains.
module smp_mem_ctrl
   import smp_pkg::*;
#(
   parameter int ADDR_W   = SMP_ADDR_W,
   parameter int DATA_W   = SMP_DATA_W,
   parameter int WB_DEPTH = 4,
   parameter int MEM_LAT  = 2
) (
   input  logic           clk,
   input  logic           rst,
   smp_mem_ctrl_if.slave  bus
);

   localparam int              CNT_W    = $clog2(MEM_LAT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

   mem_ctrl_state_t   state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              mem_we_q, mem_we_d;

   logic              pop;
   logic              full, empty, hit;
   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] head_data, hit_data;
   logic              fill_rdy, fill_acc;

   smp_wb_fifo #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (WB_DEPTH)
   ) u_wb_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (bus.wb_vld && bus.wb_rdy),
      .push_addr_i (bus.wb_addr),
      .push_data_i (bus.wb_data),
      .pop_i       (pop),
      .head_addr_o (head_addr),
      .head_data_o (head_data),
      .full_o      (full),
      .empty_o     (empty),
      .cmp_addr_i  (bus.req_addr),
      .hit_o       (hit),
      .hit_data_o  (hit_data)
   );

`ifdef SMP_WB_FWD_EN
   assign fill_rdy = (state_q == IDLE) && !full && !rst;
`else
   // A fill that matches a pending write-back must wait for it to reach memory.
   assign fill_rdy = (state_q == IDLE) && !full && !rst && !hit;
   logic unused_hit_data;
   assign unused_hit_data = ^hit_data;
`endif
   assign fill_acc = bus.req_vld && fill_rdy;

   // Next-state and datapath decisions; drains beat fills only when full.
   always_comb begin
      state_d     = state_q;
      cnt_d       = '0;
      pop         = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rsp_addr_d  = rsp_addr_q;
      rsp_data_d  = rsp_data_q;
      unique case (state_q)
         IDLE: begin
            if (full || (!fill_acc && !empty)) begin
               pop         = 1'b1;
               mem_we_d    = 1'b1;
               mem_addr_d  = head_addr;
               mem_wdata_d = head_data;
               state_d     = WR_WAIT;
            end else if (fill_acc) begin
               rsp_addr_d = bus.req_addr;
`ifdef SMP_WB_FWD_EN
               if (hit) begin
                  rsp_data_d = hit_data;
                  state_d    = RSP;
               end else begin
                  mem_addr_d = bus.req_addr;
                  state_d    = RD;
               end
`else
               mem_addr_d = bus.req_addr;
               state_d    = RD;
`endif
            end
         end
         RD: state_d = RD_WAIT;
         RD_WAIT: begin
            if (cnt_q == CNT_LAST) begin
               rsp_data_d = bus.mem_rdata;
               state_d    = RSP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RSP: state_d = IDLE;
         WR_WAIT: begin
            if (cnt_q == CNT_LAST) state_d = IDLE;
            else                   cnt_d   = cnt_q + CNT_W'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset abandons any in-flight read.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rsp_addr_q  <= '0;
         rsp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rsp_addr_q  <= rsp_addr_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   assign bus.req_rdy   = fill_rdy;
   assign bus.wb_rdy    = !full && !rst;
   assign bus.rsp_vld   = (state_q == RSP);
   assign bus.rsp_addr  = rsp_addr_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.mem_re    = (state_q == RD);
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_smp_mem_ctrl.sv
// Directed bench for smp_mem_ctrl: vector table of isolated fills/write-backs
// plus hand-written sequences for buffer-full, forwarding and reset cases.
`timescale 1ns/1ps
module tb_smp_mem_ctrl;

   localparam int ADDR_W   = 11;
   localparam int DATA_W   = 16;
   localparam int WB_DEPTH = 4;
   localparam int MEM_LAT  = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   smp_mem_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

   smp_mem_ctrl #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .WB_DEPTH (WB_DEPTH),
      .MEM_LAT  (MEM_LAT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   // Memory model: read data appears MEM_LAT cycles after the mem_re cycle.
   logic [DATA_W-1:0] mem [2048];
   logic [DATA_W-1:0] rd_pipe [MEM_LAT];
   always @(posedge clk) begin
      rd_pipe[0] <= bus_if.mem_re ? mem[bus_if.mem_addr] : 16'hDEAD;
      for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
      if (bus_if.mem_we) mem[bus_if.mem_addr] = bus_if.mem_wdata;
   end
   assign bus_if.mem_rdata = rd_pipe[MEM_LAT-1];

   typedef struct {
      int                cyc;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } ev_t;

   ev_t rsp_q[$];
   ev_t we_q[$];
   ev_t re_q[$];

   always @(negedge clk) begin
      if (bus_if.rsp_vld) rsp_q.push_back('{cyc, bus_if.rsp_addr, bus_if.rsp_data});
      if (bus_if.mem_we)  we_q.push_back('{cyc, bus_if.mem_addr, bus_if.mem_wdata});
      if (bus_if.mem_re)  re_q.push_back('{cyc, bus_if.mem_addr, 16'h0});
   end

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_q();
      rsp_q.delete();
      we_q.delete();
      re_q.delete();
   endtask

   // Present a fill until accepted; k is the handshake cycle.
   task automatic fill_start(input logic [ADDR_W-1:0] a, output int k);
      k = -1;
      bus_if.req_vld  = 1'b1;
      bus_if.req_addr = a;
      for (int n = 0; n < 40; n++) begin
         #1;
         if (bus_if.req_rdy) begin
            k = cyc;
            break;
         end
         @(negedge clk);
      end
      chk("fill_accepted", (k >= 0), 1);
      @(negedge clk); #1;
      bus_if.req_vld = 1'b0;
   endtask

   // Present a write-back until accepted; k is the handshake cycle.
   task automatic wb_send(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, output int k);
      k = -1;
      bus_if.wb_vld  = 1'b1;
      bus_if.wb_addr = a;
      bus_if.wb_data = d;
      for (int n = 0; n < 40; n++) begin
         #1;
         if (bus_if.wb_rdy) begin
            k = cyc;
            break;
         end
         @(negedge clk);
      end
      chk("wb_accepted", (k >= 0), 1);
      @(negedge clk); #1;
      bus_if.wb_vld = 1'b0;
   endtask

   task automatic wait_cycles(input int n, output int rdy_low);
      rdy_low = 0;
      repeat (n) begin
         @(negedge clk); #1;
         if (!bus_if.wb_rdy) rdy_low++;
      end
   endtask

   typedef struct {
      bit                is_fill;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      int                exp_lat;
   } vec_t;

   vec_t vecs [7];

   initial begin
      int k, k0, k1, ka, kb, lows;
      int kw [4];

      vecs[0] = '{1'b1, 11'h123, 16'hBEEF, 4};
      vecs[1] = '{1'b0, 11'h010, 16'hAAAA, 2};
      vecs[2] = '{1'b1, 11'h010, 16'hAAAA, 4};
      vecs[3] = '{1'b1, 11'h7FF, 16'h1234, 4};
      vecs[4] = '{1'b0, 11'h7FF, 16'h0F0F, 2};
      vecs[5] = '{1'b1, 11'h7FF, 16'h0F0F, 4};
      vecs[6] = '{1'b1, 11'h000, 16'hC001, 4};

      for (int i = 0; i < 2048; i++) mem[i] = 16'h0;
      mem[11'h123] = 16'hBEEF;
      mem[11'h7FF] = 16'h1234;
      mem[11'h000] = 16'hC001;
      mem[11'h200] = 16'h5A5A;

      bus_if.req_vld  = 1'b0;
      bus_if.req_addr = '0;
      bus_if.wb_vld   = 1'b0;
      bus_if.wb_addr  = '0;
      bus_if.wb_data  = '0;

      // Reset values
      repeat (3) @(negedge clk);
      #1;
      chk("rst_req_rdy",   bus_if.req_rdy,   0);
      chk("rst_wb_rdy",    bus_if.wb_rdy,    0);
      chk("rst_rsp_vld",   bus_if.rsp_vld,   0);
      chk("rst_mem_re",    bus_if.mem_re,    0);
      chk("rst_mem_we",    bus_if.mem_we,    0);
      chk("rst_rsp_addr",  bus_if.rsp_addr,  0);
      chk("rst_rsp_data",  bus_if.rsp_data,  0);
      chk("rst_mem_addr",  bus_if.mem_addr,  0);
      chk("rst_mem_wdata", bus_if.mem_wdata, 0);
      rst = 1'b0;
      #1;
      chk("post_rst_req_rdy", bus_if.req_rdy, 1);
      chk("post_rst_wb_rdy",  bus_if.wb_rdy,  1);
      $display("reset: outputs idle, ready after release");
      @(negedge clk); #1;

      // Vector table: isolated transactions
      for (int v = 0; v < 7; v++) begin
         clear_q();
         if (vecs[v].is_fill) begin
            fill_start(vecs[v].addr, k);
            wait_cycles(12, lows);
            chk($sformatf("v%0d_rsp_cnt", v),  rsp_q.size(), 1);
            chk($sformatf("v%0d_rsp_lat", v),  rsp_q[0].cyc - k, vecs[v].exp_lat);
            chk($sformatf("v%0d_rsp_addr", v), rsp_q[0].addr, vecs[v].addr);
            chk($sformatf("v%0d_rsp_data", v), rsp_q[0].data, vecs[v].data);
            chk($sformatf("v%0d_re_cnt", v),   re_q.size(), 1);
            chk($sformatf("v%0d_re_lat", v),   re_q[0].cyc - k, 1);
            chk($sformatf("v%0d_re_addr", v),  re_q[0].addr, vecs[v].addr);
            chk($sformatf("v%0d_we_cnt", v),   we_q.size(), 0);
            $display("vec %0d: fill addr 0x%0h -> data 0x%0h", v, vecs[v].addr, rsp_q[0].data);
         end else begin
            wb_send(vecs[v].addr, vecs[v].data, k);
            wait_cycles(12, lows);
            chk($sformatf("v%0d_we_cnt", v),   we_q.size(), 1);
            chk($sformatf("v%0d_we_lat", v),   we_q[0].cyc - k, vecs[v].exp_lat);
            chk($sformatf("v%0d_we_addr", v),  we_q[0].addr, vecs[v].addr);
            chk($sformatf("v%0d_we_data", v),  we_q[0].data, vecs[v].data);
            chk($sformatf("v%0d_re_cnt", v),   re_q.size(), 0);
            chk($sformatf("v%0d_rsp_cnt", v),  rsp_q.size(), 0);
            chk($sformatf("v%0d_wb_rdy_low", v), lows, 0);
            $display("vec %0d: write-back addr 0x%0h data 0x%0h", v, vecs[v].addr, vecs[v].data);
         end
      end

      // Two back-to-back drains are spaced by MEM_LAT busy cycles plus IDLE
      clear_q();
      wb_send(11'h020, 16'h0001, ka);
      wb_send(11'h021, 16'h0002, kb);
      wait_cycles(12, lows);
      chk("drain2_cnt",     we_q.size(), 2);
      chk("drain2_first",   we_q[0].cyc - ka, 2);
      chk("drain2_spacing", we_q[1].cyc - we_q[0].cyc, MEM_LAT + 1);
      chk("drain2_addr1",   we_q[1].addr, 11'h021);
      $display("seq drain-spacing: mem_we at %0d and %0d", we_q[0].cyc, we_q[1].cyc);

      // Fill the buffer while a read is outstanding
      clear_q();
      fill_start(11'h123, k0);
      for (int i = 0; i < 4; i++) wb_send(11'h030 + 11'(i), 16'hD000 + 16'(i), kw[i]);
      bus_if.req_addr = 11'h200;
      bus_if.req_vld  = 1'b1;
      #1;
      chk("full_wb_rdy",  bus_if.wb_rdy,  0);
      chk("full_req_rdy", bus_if.req_rdy, 0);
      fill_start(11'h200, k1);
      wait_cycles(20, lows);
      for (int i = 0; i < 4; i++) chk($sformatf("full_wb%0d_cyc", i), kw[i] - k0, i + 1);
      chk("full_accept_cyc", k1 - k0, 8);
      chk("full_rsp_cnt",    rsp_q.size(), 2);
      chk("full_rsp0_cyc",   rsp_q[0].cyc - k0, 4);
      chk("full_rsp0_data",  rsp_q[0].data, 16'hBEEF);
      chk("full_rsp1_addr",  rsp_q[1].addr, 11'h200);
      chk("full_rsp1_data",  rsp_q[1].data, 16'h5A5A);
      chk("full_rsp1_cyc",   rsp_q[1].cyc - k1, 4);
      chk("full_we_cnt",     we_q.size(), 4);
      chk("full_we0_cyc",    we_q[0].cyc - k0, 6);
      for (int i = 0; i < 4; i++) chk($sformatf("full_we%0d_addr", i), we_q[i].addr, 11'h030 + 11'(i));
      $display("seq buffer-full: second fill accepted %0d cycles after first", k1 - k0);

      // Duplicate write-backs then a fill of the same block
      clear_q();
      fill_start(11'h123, k0);
      wb_send(11'h040, 16'h1111, ka);
      wb_send(11'h040, 16'h2222, kb);
      fill_start(11'h040, k1);
      wait_cycles(20, lows);
      chk("dup_we_cnt",   we_q.size(), 2);
      chk("dup_we0_data", we_q[0].data, 16'h1111);
      chk("dup_we1_data", we_q[1].data, 16'h2222);
      chk("dup_rsp_cnt",  rsp_q.size(), 2);
      chk("dup_rsp_addr", rsp_q[1].addr, 11'h040);
      chk("dup_rsp_data", rsp_q[1].data, 16'h2222);
`ifdef SMP_WB_FWD_EN
      chk("dup_fwd_accept", k1 - k0, 5);
      chk("dup_fwd_rsp_lat", rsp_q[1].cyc - k1, 1);
      chk("dup_fwd_re_cnt", re_q.size(), 1);
`else
      chk("dup_accept",    k1 - k0, 11);
      chk("dup_we0_cyc",   we_q[0].cyc - k0, 6);
      chk("dup_we1_cyc",   we_q[1].cyc - k0, 9);
      chk("dup_re_cnt",    re_q.size(), 2);
      chk("dup_re_addr",   re_q[1].addr, 11'h040);
      chk("dup_re_cyc",    re_q[1].cyc - k1, 1);
      chk("dup_rsp_lat",   rsp_q[1].cyc - k1, 4);
`endif
      $display("seq duplicate-wb: fill 0x040 returned 0x%0h", rsp_q[1].data);

      // Reset during RD_WAIT with two entries buffered
      fill_start(11'h123, k0);
      wb_send(11'h050, 16'h5050, ka);
      wb_send(11'h051, 16'h5151, kb);
      rst = 1'b1;
      clear_q();
      @(negedge clk); #1;
      chk("midrst_wb_rdy",  bus_if.wb_rdy,  0);
      chk("midrst_req_rdy", bus_if.req_rdy, 0);
      @(negedge clk); #1;
      rst = 1'b0;
      #1;
      chk("midrst_post_wb_rdy",  bus_if.wb_rdy,  1);
      chk("midrst_post_req_rdy", bus_if.req_rdy, 1);
      wait_cycles(15, lows);
      chk("midrst_rsp_cnt", rsp_q.size(), 0);
      chk("midrst_we_cnt",  we_q.size(), 0);
      chk("midrst_re_cnt",  re_q.size(), 0);
      $display("seq mid-reset: %0d responses, %0d writes after reset", rsp_q.size(), we_q.size());

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
